// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b memory-side types and the arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } arb_state_t;

  // Consecutive contested data grants allowed before the instruction side wins.
  localparam logic [1:0] STARVE_LIMIT = 2'd2;

  function automatic logic is_busy(arb_state_t s);
    return (s == I_BUSY) || (s == D_BUSY);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and physical-memory ports around the arbiter.
interface mem_arbiter_if;
  import lc3b_types::*;

  logic     i_read;
  lc3b_word i_address;
  lc3b_line i_rdata;
  logic     i_resp;

  logic     d_read;
  logic     d_write;
  lc3b_word d_address;
  lc3b_line d_wdata;
  lc3b_line d_rdata;
  logic     d_resp;

  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/mem_arbiter_register.sv
// Generic load-enabled register with asynchronous clear; used for the returned-line latches.
module register #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= '0;
    else if (load)
      value <= data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-cache and data-cache line transactions onto one physical-memory port.
//
//   state  | meaning
//   IDLE   | sample requests, grant one side, capture address/wdata
//   I_BUSY | instruction fill in flight on pmem
//   D_BUSY | data fill or writeback in flight on pmem
//   I_DONE | one-cycle i_resp with latched line
//   D_DONE | one-cycle d_resp with latched line
module mem_arbiter
  import lc3b_types::*;
(
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t state_next;
  logic       grant_i;
  logic       grant_d;
  logic       req_d;
  lc3b_word   addr_q;
  lc3b_line   wdata_q;
  logic       write_q;
  logic [1:0] starve_cnt;

  assign req_d = bus.d_read | bus.d_write;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (req_d && (!bus.i_read || starve_cnt != STARVE_LIMIT)) begin
          grant_d    = 1'b1;
          state_next = D_BUSY;
        end else if (bus.i_read) begin
          grant_i    = 1'b1;
          state_next = I_BUSY;
        end
      end
      I_BUSY:  if (bus.pmem_resp) state_next = I_DONE;
      D_BUSY:  if (bus.pmem_resp) state_next = D_DONE;
      I_DONE:  state_next = IDLE;
      D_DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        addr_q     <= bus.d_address;
        wdata_q    <= bus.d_wdata;
        write_q    <= bus.d_write;
        // Only data wins that actually held off a pending instruction fill count toward starvation.
        starve_cnt <= bus.i_read ? starve_cnt + 2'd1 : 2'd0;
      end else if (grant_i) begin
        addr_q     <= bus.i_address;
        write_q    <= 1'b0;
        starve_cnt <= '0;
      end
    end
  end

  assign bus.pmem_read    = (state == I_BUSY) || ((state == D_BUSY) && !write_q);
  assign bus.pmem_write   = (state == D_BUSY) && write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_resp       = (state == I_DONE);
  assign bus.d_resp       = (state == D_DONE);

  register #(.WIDTH(128)) i_line (
    .clk   (clk),
    .reset (reset),
    .load  (is_busy(state) && (state == I_BUSY) && bus.pmem_resp),
    .data  (bus.pmem_rdata),
    .value (bus.i_rdata)
  );

  register #(.WIDTH(128)) d_line (
    .clk   (clk),
    .reset (reset),
    .load  (is_busy(state) && (state == D_BUSY) && bus.pmem_resp),
    .data  (bus.pmem_rdata),
    .value (bus.d_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected responses, a monitor pops them.
module tb_mem_arbiter;
  import lc3b_types::*;

  typedef struct {
    bit       side;
    bit       wr;
    lc3b_line data;
  } exp_t;

  logic clk;
  logic reset;
  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_i = 0;
  int   n_d = 0;
  int   mem_delay = 3;
  bit   spurious = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic lc3b_line line_for(lc3b_word a);
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a}};
  endfunction

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(string name, lc3b_word act, lc3b_word exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_line(string name, lc3b_line act, lc3b_line exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(bit side, bit wr, lc3b_line data);
    exp_t e;
    e.side = side;
    e.wr   = wr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic pop_check(bit side, lc3b_line data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp side %0d got a response expected none", side);
      return;
    end
    e = sb.pop_front();
    check_bit("resp_side", side, e.side);
    if (!e.wr) check_line("resp_line", data, e.data);
  endtask

  task automatic wait_resp(bit side, int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (side ? bus.d_resp : bus.i_resp) return;
    end
    checks++;
    errors++;
    $display("FAIL resp_timeout side %0d got no response expected one within %0d cycles", side, budget);
  endtask

  // Memory model: answers each command after mem_delay cycles with an address-derived line.
  initial begin
    int seen;
    seen = 0;
    bus.pmem_resp  = 0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 0;
      if (spurious) begin
        bus.pmem_resp  = 1;
        bus.pmem_rdata = {8{16'hDEAD}};
      end else if (bus.pmem_read || bus.pmem_write) begin
        seen++;
        if (seen >= mem_delay) begin
          bus.pmem_resp  = 1;
          bus.pmem_rdata = line_for(bus.pmem_address);
          seen = 0;
        end
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.i_resp) begin
        n_i++;
        pop_check(1'b0, bus.i_rdata);
      end
      if (bus.d_resp) begin
        n_d++;
        pop_check(1'b1, bus.d_rdata);
      end
    end
  end

  initial begin
    int ni0, nd0;
    reset         = 1;
    bus.i_read    = 0;
    bus.i_address = '0;
    bus.d_read    = 0;
    bus.d_write   = 0;
    bus.d_address = '0;
    bus.d_wdata   = '0;

    #12;
    check_bit("rst_pmem_read", bus.pmem_read, 1'b0);
    check_bit("rst_pmem_write", bus.pmem_write, 1'b0);
    check_bit("rst_i_resp", bus.i_resp, 1'b0);
    check_bit("rst_d_resp", bus.d_resp, 1'b0);
    check_word("rst_pmem_address", bus.pmem_address, 16'h0000);
    check_line("rst_i_rdata", bus.i_rdata, '0);
    check_line("rst_d_rdata", bus.d_rdata, '0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Lone instruction fill.
    mem_delay     = 3;
    bus.i_read    = 1;
    bus.i_address = 16'h1230;
    push(1'b0, 1'b0, {16{8'hA5}});
    @(negedge clk);
    check_bit("t1_pmem_read", bus.pmem_read, 1'b1);
    check_bit("t1_pmem_write", bus.pmem_write, 1'b0);
    check_word("t1_pmem_address", bus.pmem_address, 16'h1230);
    wait_resp(1'b0, 20);
    bus.i_read = 0;
    @(negedge clk);
    check_bit("t1_i_resp_pulse", bus.i_resp, 1'b0);
    check_line("t1_i_rdata_held", bus.i_rdata, {16{8'hA5}});

    // Simultaneous requests: data first, instruction next.
    bus.i_read    = 1;
    bus.i_address = 16'h2000;
    bus.d_read    = 1;
    bus.d_address = 16'h3000;
    push(1'b1, 1'b0, line_for(16'h3000));
    push(1'b0, 1'b0, line_for(16'h2000));
    @(negedge clk);
    check_word("t2_first_grant_addr", bus.pmem_address, 16'h3000);
    wait_resp(1'b1, 20);
    bus.d_read = 0;
    wait_resp(1'b0, 20);
    bus.i_read = 0;
    @(negedge clk);

    // Data keeps re-requesting: D, D, then the instruction side must win.
    bus.i_read    = 1;
    bus.i_address = 16'h2100;
    bus.d_read    = 1;
    bus.d_address = 16'h3100;
    push(1'b1, 1'b0, line_for(16'h3100));
    push(1'b1, 1'b0, line_for(16'h3200));
    push(1'b0, 1'b0, line_for(16'h2100));
    push(1'b1, 1'b0, line_for(16'h3300));
    wait_resp(1'b1, 20);
    bus.d_address = 16'h3200;
    wait_resp(1'b1, 20);
    bus.d_address = 16'h3300;
    @(negedge clk);
    @(negedge clk);
    check_word("t2_third_grant_addr", bus.pmem_address, 16'h2100);
    check_bit("t2_third_grant_read", bus.pmem_read, 1'b1);
    wait_resp(1'b0, 20);
    bus.i_read = 0;
    wait_resp(1'b1, 20);
    bus.d_read = 0;
    @(negedge clk);

    // Writeback: requester-side changes mid-transaction must not reach pmem.
    mem_delay     = 5;
    bus.d_write   = 1;
    bus.d_address = 16'h4000;
    bus.d_wdata   = {8{16'h1111}};
    push(1'b1, 1'b1, '0);
    @(negedge clk);
    check_bit("t3_pmem_write", bus.pmem_write, 1'b1);
    check_bit("t3_pmem_read", bus.pmem_read, 1'b0);
    bus.d_address = 16'h5000;
    bus.d_wdata   = {8{16'h2222}};
    @(negedge clk);
    check_word("t3_addr_stable", bus.pmem_address, 16'h4000);
    check_line("t3_wdata_stable", bus.pmem_wdata, {8{16'h1111}});
    wait_resp(1'b1, 20);
    bus.d_write = 0;
    @(negedge clk);

    // Read and write together is a write.
    bus.d_read    = 1;
    bus.d_write   = 1;
    bus.d_address = 16'h4100;
    push(1'b1, 1'b1, '0);
    @(negedge clk);
    check_bit("t3b_pmem_write", bus.pmem_write, 1'b1);
    check_bit("t3b_pmem_read", bus.pmem_read, 1'b0);
    wait_resp(1'b1, 20);
    bus.d_read  = 0;
    bus.d_write = 0;
    @(negedge clk);

    // Spurious memory response while idle.
    ni0 = n_i;
    nd0 = n_d;
    spurious = 1;
    @(negedge clk);
    spurious = 0;
    repeat (3) @(negedge clk);
    check_word("t4_no_i_resp", 16'(n_i - ni0), 16'd0);
    check_word("t4_no_d_resp", 16'(n_d - nd0), 16'd0);
    check_bit("t4_idle_no_cmd", bus.pmem_read | bus.pmem_write, 1'b0);
    check_line("t4_i_rdata_held", bus.i_rdata, line_for(16'h2100));

    // Reset during a writeback abandons it.
    mem_delay     = 20;
    bus.d_write   = 1;
    bus.d_address = 16'h6000;
    @(negedge clk);
    check_bit("t5_busy_write", bus.pmem_write, 1'b1);
    #2 reset = 1;
    #1;
    check_bit("t5_async_drop", bus.pmem_write, 1'b0);
    check_line("t5_d_rdata_clr", bus.d_rdata, '0);
    check_word("t5_addr_clr", bus.pmem_address, 16'h0000);
    bus.d_write = 0;
    @(negedge clk);
    reset = 0;
    nd0 = n_d;
    repeat (5) @(negedge clk);
    check_word("t5_no_d_resp", 16'(n_d - nd0), 16'd0);

    mem_delay     = 2;
    bus.d_read    = 1;
    bus.d_address = 16'h7000;
    push(1'b1, 1'b0, line_for(16'h7000));
    @(negedge clk);
    check_bit("t5_post_rst_read", bus.pmem_read, 1'b1);
    wait_resp(1'b1, 20);
    bus.d_read = 0;
    repeat (3) @(negedge clk);

    check_word("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
